train_speed_ramp: RTL and testbench

Motor speed stage for the train controller, directly downstream of the 1 kHz frequency divider. It samples the divider's 1 kHz square wave as data in the 100 MHz domain, turns each rising edge into a millisecond tick, and ramps the applied speed one step per `RAMP_MS` milliseconds toward the operator's target. Direction reversals are only allowed at standstill. It also drives an emergency stop path and an 8-bit PWM output for the motor driver.

---
 rtl/train_speed_ramp.sv | 198 +++++++++++++++++++
 tb/tb_train_speed_ramp.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/train_speed_ramp.sv
// Motor speed ramp: syncs the 1 kHz divider output, ramps speed one step per RAMP_MS ticks, drives PWM.
// Latency: clk_1khz rise -> ms_tick 3 cycles, step_tick -> speed 1 cycle, estop -> speed/pwm 0 in 1 cycle.
// Backpressure: none; free-running control loop, inputs are sampled every cycle.
module train_speed_ramp #(
  parameter int RAMP_MS      = 10,
  parameter int PWM_PRESCALE = 390
) (
  input  logic       clk_100mhz,
  input  logic       rst_n,
  input  logic       clk_1khz,
  input  logic [7:0] target_speed,
  input  logic       target_dir,
  input  logic       estop,
  output logic [7:0] speed,
  output logic       dir,
  output logic       pwm,
  output logic       at_target
);

  localparam int RW = (RAMP_MS > 1) ? $clog2(RAMP_MS) : 1;
  localparam int PW = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_MS - 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(PWM_PRESCALE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEL,
    S_DECEL,
    S_CRUISE,
    S_ESTOP
  } state_t;

  logic          sync_q1;
  logic          sync_q2;
  logic          edge_q;
  logic          ms_tick;
  logic [RW-1:0] ramp_cnt;
  logic          step_tick;
  logic [7:0]    eff;
  state_t        state_q;
  state_t        state_d;
  logic [7:0]    speed_d;
  logic          dir_d;
  logic [PW-1:0] pre_cnt;
  logic [7:0]    pwm_cnt;
  logic [7:0]    duty_reg;
  logic          pwm_wrap;

  // Synchronize the divider output and detect rising edges. The chain resets
  // high so a level that is already high after reset never looks like an edge.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      edge_q  <= 1'b1;
      ms_tick <= 1'b0;
    end else begin
      sync_q1 <= clk_1khz;
      sync_q2 <= sync_q1;
      edge_q  <= sync_q2;
      ms_tick <= sync_q2 & ~edge_q;
    end
  end

  // Count millisecond ticks; held at zero while the emergency stop is active.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      ramp_cnt <= '0;
    end else if (estop) begin
      ramp_cnt <= '0;
    end else if (ms_tick) begin
      if (ramp_cnt == RAMP_LAST) begin
        ramp_cnt <= '0;
      end else begin
        ramp_cnt <= ramp_cnt + 1'b1;
      end
    end
  end

  assign step_tick = ms_tick && (ramp_cnt == RAMP_LAST);

  // A pending reversal ramps toward zero first.
  assign eff = (target_dir != dir) ? 8'd0 : target_speed;

  // Ramp state, applied speed and direction registers.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      speed   <= 8'd0;
      dir     <= 1'b0;
    end else begin
      state_q <= state_d;
      speed   <= speed_d;
      dir     <= dir_d;
    end
  end

  // Next-state and next-speed logic; estop overrides everything.
  always_comb begin
    state_d = state_q;
    speed_d = speed;
    dir_d   = dir;
    if (estop) begin
      state_d = S_ESTOP;
      speed_d = 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (target_dir != dir) begin
            dir_d = target_dir;
          end else if (eff != 8'd0) begin
            state_d = S_ACCEL;
          end
        end
        S_ACCEL: begin
          if (eff > speed) begin
            if (step_tick) speed_d = speed + 8'd1;
          end else if (eff < speed) begin
            state_d = S_DECEL;
          end else begin
            state_d = (speed == 8'd0) ? S_IDLE : S_CRUISE;
          end
        end
        S_DECEL: begin
          if (eff < speed) begin
            if (step_tick) speed_d = speed - 8'd1;
          end else if (eff > speed) begin
            state_d = S_ACCEL;
          end else begin
            state_d = (speed == 8'd0) ? S_IDLE : S_CRUISE;
          end
        end
        S_CRUISE: begin
          if (eff > speed) begin
            state_d = S_ACCEL;
          end else if (eff < speed) begin
            state_d = S_DECEL;
          end else if (speed == 8'd0) begin
            state_d = S_IDLE;
          end
        end
        S_ESTOP: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Registered on-target flag.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      at_target <= 1'b0;
    end else begin
      at_target <= (speed == target_speed) && (dir == target_dir);
    end
  end

  // PWM prescaler and 8-bit period counter.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      pwm_cnt <= 8'd0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
      pwm_cnt <= pwm_cnt + 8'd1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  assign pwm_wrap = (pre_cnt == PRE_LAST) && (pwm_cnt == 8'hFF);

  // Duty is only reloaded at a period boundary so a period never glitches.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      duty_reg <= 8'd0;
    end else if (estop) begin
      duty_reg <= 8'd0;
    end else if (pwm_wrap) begin
      duty_reg <= speed;
    end
  end

  // Registered PWM compare, forced low during an emergency stop.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      pwm <= 1'b0;
    end else if (estop) begin
      pwm <= 1'b0;
    end else begin
      pwm <= (pwm_cnt < duty_reg);
    end
  end

endmodule

// File: tb/tb_train_speed_ramp.sv
// Testbench for train_speed_ramp: directed scenarios plus randomized targets
// checked against a per-millisecond behavioural model of the ramp rules.
module tb_train_speed_ramp;

  localparam int RAMP = 2;

  logic       clk_100mhz;
  logic       rst_n;
  logic       clk_1khz;
  logic [7:0] target_speed;
  logic       target_dir;
  logic       estop;
  logic [7:0] speed;
  logic       dir;
  logic       pwm;
  logic       at_target;

  int errors;
  int checks;
  int mspd;
  int msc;
  bit mdir;

  train_speed_ramp #(
    .RAMP_MS     (RAMP),
    .PWM_PRESCALE(1)
  ) dut (
    .clk_100mhz  (clk_100mhz),
    .rst_n       (rst_n),
    .clk_1khz    (clk_1khz),
    .target_speed(target_speed),
    .target_dir  (target_dir),
    .estop       (estop),
    .speed       (speed),
    .dir         (dir),
    .pwm         (pwm),
    .at_target   (at_target)
  );

  initial clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  task automatic cycle();
    @(posedge clk_100mhz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One millisecond of the speed law: estop zeroes speed and the tick count;
  // otherwise every RAMP-th divider rise moves speed one unit toward the
  // effective target, and a standing train adopts the requested direction.
  task automatic model_ms(input bit rise, input bit es);
    int eff;
    if (es) begin
      mspd = 0;
      msc  = 0;
    end else begin
      if (mspd == 0 && target_dir != mdir) mdir = target_dir;
      if (rise) begin
        msc++;
        if (msc == RAMP) begin
          msc = 0;
          eff = (target_dir != mdir) ? 0 : int'(target_speed);
          if (eff > mspd) mspd++;
          else if (eff < mspd) mspd--;
        end
      end
      if (mspd == 0 && target_dir != mdir) mdir = target_dir;
    end
  endtask

  // Run one 20-cycle millisecond of the divider (high 10, low 10, or held high).
  task automatic run_ms(input bit hold_high);
    bit   rise;
    bit   es;
    logic cond;
    logic es_prev;
    rise     = (clk_1khz == 1'b0);
    es       = estop;
    clk_1khz = 1'b1;
    for (int p = 0; p < 20; p++) begin
      if (p == 10 && !hold_high) clk_1khz = 1'b0;
      cond    = (speed == target_speed) && (dir == target_dir);
      es_prev = estop;
      cycle();
      chk("at_target_reg", at_target, cond);
      if (es_prev) begin
        chk("estop_speed", speed, 0);
        chk("estop_pwm", pwm, 0);
      end
    end
    model_ms(rise, es);
    chk("ms_speed", speed, mspd);
    chk("ms_dir", dir, mdir);
    chk("ms_at_target", at_target, (mspd == int'(target_speed)) && (mdir == target_dir));
  endtask

  task automatic pwm_count(input int exp, input string tag);
    int hi;
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      cycle();
      if (pwm) hi++;
    end
    chk(tag, hi, exp);
  endtask

  initial begin
    int n;
    int frozen;
    errors       = 0;
    checks       = 0;
    mspd         = 0;
    msc          = 0;
    mdir         = 1'b0;
    rst_n        = 1'b0;
    clk_1khz     = 1'b0;
    target_speed = 8'd0;
    target_dir   = 1'b0;
    estop        = 1'b0;

    // Power-on reset values.
    repeat (3) cycle();
    chk("rst_speed", speed, 0);
    chk("rst_dir", dir, 0);
    chk("rst_pwm", pwm, 0);
    chk("rst_at_target", at_target, 0);
    rst_n = 1'b1;
    repeat (2) cycle();

    // Accelerate 0 -> 3 forward.
    target_speed = 8'd3;
    target_dir   = 1'b0;
    repeat (8) run_ms(1'b0);
    chk("accel_speed", speed, 3);
    chk("accel_at_target", at_target, 1);

    // Reverse at speed: down to 0, flip, back up to 3.
    target_dir = 1'b1;
    repeat (14) run_ms(1'b0);
    chk("reverse_speed", speed, 3);
    chk("reverse_dir", dir, 1);

    // Asynchronous reset mid-run, then release with the divider held high.
    rst_n = 1'b0;
    #1;
    chk("midrst_speed", speed, 0);
    chk("midrst_dir", dir, 0);
    chk("midrst_pwm", pwm, 0);
    chk("midrst_at_target", at_target, 0);
    cycle();
    clk_1khz   = 1'b1;
    target_dir = 1'b0;
    cycle();
    rst_n = 1'b1;
    repeat (40) cycle();
    chk("postrst_speed", speed, 0);
    chk("postrst_at_target", at_target, 0);
    mspd = 0;
    msc  = 0;
    mdir = 1'b0;

    // Emergency stop during acceleration at speed 2.
    n = 0;
    while (mspd != 2 && n < 20) begin
      run_ms(1'b0);
      n++;
    end
    chk("pre_estop_speed", speed, 2);
    estop = 1'b1;
    repeat (3) run_ms(1'b0);
    chk("estop_hold_speed", speed, 0);
    chk("estop_hold_pwm", pwm, 0);
    estop = 1'b0;
    repeat (8) run_ms(1'b0);
    chk("estop_recover_speed", speed, 3);

    // Randomized targets, directions and stops against the model.
    repeat (60) begin
      if ($urandom % 4 == 0) target_speed = 8'($urandom_range(0, 6));
      if ($urandom % 5 == 0) target_dir = ~target_dir;
      estop = ($urandom % 8 == 0);
      run_ms(1'b0);
    end
    estop = 1'b0;

    // Stalled divider: speed freezes short of target 5.
    target_speed = 8'd5;
    target_dir   = 1'b0;
    n = 0;
    while ((mspd != 2 || mdir != 1'b0) && n < 60) begin
      run_ms(1'b0);
      n++;
    end
    run_ms(1'b1);
    frozen = mspd;
    repeat (6) run_ms(1'b1);
    chk("stall_frozen", speed, frozen);
    run_ms(1'b0);

    // PWM duty at 64 and then 128.
    target_speed = 8'd64;
    n = 0;
    while (mspd != 64 && n < 300) begin
      run_ms(1'b0);
      n++;
    end
    repeat (15) run_ms(1'b1);
    pwm_count(64, "pwm_duty64");
    target_speed = 8'd128;
    n = 0;
    while (mspd != 128 && n < 300) begin
      run_ms(1'b0);
      n++;
    end
    repeat (15) run_ms(1'b1);
    pwm_count(128, "pwm_duty128");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
